mult_div_unit: RTL



---
 rtl/cpu_pkg.sv | 34 +++
 rtl/md_iter_datapath.sv | 59 +++++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  // Wide enough for any supported W; users slice the low W bits.
  localparam logic [63:0] MD_DIV0_LO = '1;

  function automatic logic op_is_div(input md_op_t o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_t o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_datapath.sv
`default_nettype none
// ============================================================================
// Module      : md_iter_datapath
// Description : 2W accumulator with one radix-2 shift-add / restoring
//               shift-subtract step per enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module md_iter_datapath #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           mode_div,
  input  logic [W-1:0]   load_operand,
  input  logic [W-1:0]   load_init,
  output logic [2*W-1:0] acc
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   operand_q, operand_d;
  logic [W:0]     sum;
  logic [W:0]     diff;

  always_comb begin
    acc_d     = acc_q;
    operand_d = operand_q;
    // Multiply: {acc_hi, multiplier} shifts right, adding the multiplicand on a 1.
    sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? operand_q : '0)};
    // Divide: {remainder, quotient} shifts left; a borrow in bit W means restore.
    diff = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, operand_q};
    if (load) begin
      acc_d     = {{W{1'b0}}, load_init};
      operand_d = load_operand;
    end else if (step) begin
      if (mode_div) begin
        if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
        else          acc_d = {acc_q[2*W-2:0], 1'b0};
      end else begin
        acc_d = {sum, acc_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      operand_q <= '0;
    end else begin
      acc_q     <= acc_d;
      operand_q <= operand_d;
    end
  end

  assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         hi_we,
  input  logic         lo_we,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_by_zero
);

  md_state_t        state_q, state_d;
  md_op_t           op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             div0_q, div0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  md_op_t         op_in;
  logic           in_div, a_neg, b_neg, b_zero;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] acc, prod;
  logic [W-1:0]   quot, rem, div0_hi;

  assign op_in  = md_op_t'(op);
  assign in_div = op_is_div(op_in);
  assign b_zero = (src_b == '0);
  assign a_neg  = op_is_signed(op_in) & src_a[W-1];
  assign b_neg  = op_is_signed(op_in) & src_b[W-1];
  assign a_mag  = a_neg ? -src_a : src_a;
  assign b_mag  = b_neg ? -src_b : src_b;

  md_iter_datapath #(.W(W)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .load         ((state_q == IDLE) && start),
    .step         (state_q == RUN),
    .mode_div     (op_is_div(op_q)),
    .load_operand (in_div ? b_mag : a_mag),
    .load_init    (in_div ? a_mag : b_mag),
    .acc          (acc)
  );

  // Quotient/product take the XOR of signs; remainder follows the dividend.
  assign prod    = (neg_a_q ^ neg_b_q) ? -acc : acc;
  assign quot    = (neg_a_q ^ neg_b_q) ? -acc[W-1:0] : acc[W-1:0];
  assign rem     = neg_a_q ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign div0_hi = neg_a_q ? -acc[W-1:0] : acc[W-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = src_a;
        if (lo_we) lo_d = src_a;
        if (start) begin
          op_d    = op_in;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          div0_d  = in_div && b_zero;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (in_div && b_zero) ? FIX : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) state_d = FIX;
      end
      FIX: begin
        if (div0_q) begin
          hi_d  = div0_hi;
          lo_d  = MD_DIV0_LO[W-1:0];
          dbz_d = 1'b1;
        end else if (op_is_div(op_q)) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          {hi_d, lo_d} = prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
